// File: rtl/fft_twiddle_mult.sv
// rtl/fft_twiddle_mult.sv - twiddle address generation and rounded, saturated complex multiply
// for the 128-point SDF FFT; three-stage pipeline, one sample per clock.
module fft_twiddle_mult #(
    parameter int WIDTH = 16,
    parameter int LOG_N = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic [LOG_N-1:0] tw_addr,
    input  logic [WIDTH-1:0] tw_re,
    input  logic [WIDTH-1:0] tw_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic             do_last
);
    localparam int PW = 2 * WIDTH;
    localparam int SW = PW + 1;
    localparam logic signed [SW-1:0] RND_K = {{(SW-WIDTH+1){1'b0}}, 1'b1, {(WIDTH-2){1'b0}}};

    function automatic logic signed [PW-1:0] sext(input logic [WIDTH-1:0] x);
        return {{WIDTH{x[WIDTH-1]}}, x};
    endfunction

    // After the rounding shift the value is valid only if all bits from WIDTH-1 up agree.
    function automatic logic [WIDTH-1:0] saturate(input logic signed [SW-1:0] v);
        if ((&v[SW-1:WIDTH-1]) || !(|v[SW-1:WIDTH-1]))
            return v[WIDTH-1:0];
        else if (v[SW-1])
            return {1'b1, {(WIDTH-1){1'b0}}};
        else
            return {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    logic [LOG_N-1:0] count;
    logic [LOG_N-1:0] addr_lo;
    logic [LOG_N-1:0] addr_hi;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (di_en)
            count <= count + 1'b1;
    end

    // Address = low bits times the bit-reversed top two bits of the count.
    always_comb begin
        addr_lo = '0;
        addr_hi = '0;
        addr_lo[LOG_N-3:0] = count[LOG_N-3:0];
        addr_hi[0] = count[LOG_N-1];
        addr_hi[1] = count[LOG_N-2];
        tw_addr = di_en ? addr_lo * addr_hi : '0;
    end

    logic             s1_valid;
    logic             s1_bypass;
    logic             s1_last;
    logic [WIDTH-1:0] s1_re;
    logic [WIDTH-1:0] s1_im;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_bypass <= 1'b0;
            s1_last   <= 1'b0;
            s1_re     <= '0;
            s1_im     <= '0;
        end else begin
            s1_valid  <= di_en;
            s1_bypass <= (tw_addr == '0);
            s1_last   <= (count == '1);
            if (di_en) begin
                s1_re <= di_re;
                s1_im <= di_im;
            end
        end
    end

    logic                 s2_valid;
    logic                 s2_bypass;
    logic                 s2_last;
    logic [WIDTH-1:0]     s2_re;
    logic [WIDTH-1:0]     s2_im;
    logic signed [PW-1:0] p_rr;
    logic signed [PW-1:0] p_ii;
    logic signed [PW-1:0] p_ri;
    logic signed [PW-1:0] p_ir;

    // The table output arrives here, one cycle behind the address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            s2_bypass <= 1'b0;
            s2_last   <= 1'b0;
            s2_re     <= '0;
            s2_im     <= '0;
            p_rr      <= '0;
            p_ii      <= '0;
            p_ri      <= '0;
            p_ir      <= '0;
        end else begin
            s2_valid  <= s1_valid;
            s2_bypass <= s1_bypass;
            s2_last   <= s1_last;
            if (s1_valid) begin
                s2_re <= s1_re;
                s2_im <= s1_im;
                p_rr  <= sext(s1_re) * sext(tw_re);
                p_ii  <= sext(s1_im) * sext(tw_im);
                p_ri  <= sext(s1_re) * sext(tw_im);
                p_ir  <= sext(s1_im) * sext(tw_re);
            end
        end
    end

    logic signed [SW-1:0] sum_re;
    logic signed [SW-1:0] sum_im;
    logic signed [SW-1:0] rnd_re;
    logic signed [SW-1:0] rnd_im;
    logic signed [SW-1:0] sh_re;
    logic signed [SW-1:0] sh_im;

    always_comb begin
        sum_re = {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii};
        sum_im = {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir};
        rnd_re = sum_re + RND_K;
        rnd_im = sum_im + RND_K;
        sh_re  = rnd_re >>> (WIDTH - 1);
        sh_im  = rnd_im >>> (WIDTH - 1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            do_en   <= 1'b0;
            do_last <= 1'b0;
            do_re   <= '0;
            do_im   <= '0;
        end else begin
            do_en   <= s2_valid;
            do_last <= s2_valid && s2_last;
            if (s2_valid) begin
                do_re <= s2_bypass ? s2_re : saturate(sh_re);
                do_im <= s2_bypass ? s2_im : saturate(sh_im);
            end
        end
    end
endmodule

// File: tb/tb_fft_twiddle_mult.sv
// tb/tb_fft_twiddle_mult.sv - directed and gapped-stream checks of fft_twiddle_mult.
module tb_fft_twiddle_mult;
    logic        clock;
    logic        reset;
    logic        di_en;
    logic [15:0] di_re;
    logic [15:0] di_im;
    logic [6:0]  tw_addr;
    logic [15:0] tw_re;
    logic [15:0] tw_im;
    logic        do_en;
    logic [15:0] do_re;
    logic [15:0] do_im;
    logic        do_last;

    fft_twiddle_mult #(.WIDTH(16), .LOG_N(7)) dut (
        .clock   (clock),
        .reset   (reset),
        .di_en   (di_en),
        .di_re   (di_re),
        .di_im   (di_im),
        .tw_addr (tw_addr),
        .tw_re   (tw_re),
        .tw_im   (tw_im),
        .do_en   (do_en),
        .do_re   (do_re),
        .do_im   (do_im),
        .do_last (do_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [15:0] tab_re [128];
    logic [15:0] tab_im [128];

    always @(posedge clock) begin
        tw_re <= tab_re[tw_addr];
        tw_im <= tab_im[tw_addr];
    end

    typedef struct {
        logic        en;
        logic        last;
        logic [15:0] re;
        logic [15:0] im;
    } ent_t;

    ent_t        pipe[$];
    logic [6:0]  m_count;
    logic [15:0] hold_re;
    logic [15:0] hold_im;
    int          n_checks;
    int          n_errors;
    int          n_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] model_addr(input logic [6:0] c);
        int lo, hi, br;
        lo = c % 32;
        hi = c / 32;
        br = (hi == 1) ? 2 : (hi == 2) ? 1 : hi;
        return 7'(lo * br);
    endfunction

    function automatic logic [15:0] sat16(input longint v);
        longint r;
        r = (v + 16384) >>> 15;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    task automatic model_reset();
        pipe.delete();
        m_count = '0;
        hold_re = '0;
        hold_im = '0;
    endtask

    task automatic step(input logic en, input logic [15:0] re, input logic [15:0] im);
        ent_t   e;
        logic [6:0] a;
        longint xr, xi, wr, wi;
        di_en = en;
        di_re = re;
        di_im = im;
        #2;
        a = en ? model_addr(m_count) : 7'd0;
        check("tw_addr", 32'(tw_addr), 32'(a));
        xr = longint'($signed(re));
        xi = longint'($signed(im));
        wr = longint'($signed(tab_re[a]));
        wi = longint'($signed(tab_im[a]));
        e.en   = en;
        e.last = en && (m_count == 7'd127);
        e.re   = (a == 0) ? re : sat16(xr * wr - xi * wi);
        e.im   = (a == 0) ? im : sat16(xr * wi + xi * wr);
        if (en) m_count = m_count + 7'd1;
        @(posedge clock);
        #1;
        pipe.push_front(e);
        if (pipe.size() > 3) void'(pipe.pop_back());
        if (pipe.size() == 3) begin
            e = pipe[2];
        end else begin
            e.en = 1'b0;
            e.last = 1'b0;
        end
        if (e.en) begin
            hold_re = e.re;
            hold_im = e.im;
        end
        if (do_last) n_last++;
        check("do_en", 32'(do_en), 32'(e.en));
        check("do_last", 32'(do_last), 32'(e.en && e.last));
        check("do_re", 32'(do_re), 32'(hold_re));
        check("do_im", 32'(do_im), 32'(hold_im));
    endtask

    initial begin
        int acc, cyc, last_at;
        n_checks = 0;
        n_errors = 0;
        n_last   = 0;
        for (int i = 0; i < 128; i++) begin
            tab_re[i] = 16'($urandom);
            tab_im[i] = 16'($urandom);
        end
        tab_re[0]  = 16'h0000; tab_im[0]  = 16'h0000;
        tab_re[2]  = 16'h0000; tab_im[2]  = 16'h8000;
        tab_re[32] = 16'h5A82; tab_im[32] = 16'hA57E;

        reset = 1'b1;
        di_en = 1'b0;
        di_re = '0;
        di_im = '0;
        #12;
        check("rst_do_en", 32'(do_en), 32'd0);
        check("rst_do_re", 32'(do_re), 32'd0);
        check("rst_do_im", 32'(do_im), 32'd0);
        check("rst_do_last", 32'(do_last), 32'd0);
        check("rst_tw_addr", 32'(tw_addr), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();

        // One contiguous frame with directed points at counts 0, 33, 48, 69, 127.
        last_at = -1;
        for (int c = 0; c < 130; c++) begin
            logic [15:0] r, m;
            r = 16'($urandom);
            m = 16'($urandom);
            if (c == 0)  begin r = 16'h1234; m = 16'h8765; end
            if (c == 33) begin r = 16'h8000; m = 16'h0000; end
            if (c == 48) begin r = 16'h4000; m = 16'h0000; end
            di_en = (c < 128);
            #1;
            if (c == 0)   check("addr_c0", 32'(tw_addr), 32'd0);
            if (c == 31)  check("addr_c31", 32'(tw_addr), 32'd0);
            if (c == 33)  check("addr_c33", 32'(tw_addr), 32'd2);
            if (c == 48)  check("addr_c48", 32'(tw_addr), 32'd32);
            if (c == 69)  check("addr_c69", 32'(tw_addr), 32'd5);
            if (c == 127) check("addr_c127", 32'(tw_addr), 32'd93);
            step(c < 128, r, m);
            if (do_last) last_at = c;
            if (c == 2)  begin
                check("bypass_re", 32'(do_re), 32'h1234);
                check("bypass_im", 32'(do_im), 32'h8765);
            end
            if (c == 35) begin
                check("sat_re", 32'(do_re), 32'h0000);
                check("sat_im", 32'(do_im), 32'h7FFF);
            end
            if (c == 50) begin
                check("mul_re", 32'(do_re), 32'h2D41);
                check("mul_im", 32'(do_im), 32'hD2BF);
            end
        end
        check("frame_last_cnt", 32'(n_last), 32'd1);
        check("frame_last_at", 32'(last_at), 32'd129);

        // Reset with the pipeline full must clear outputs without a clock edge.
        for (int c = 0; c < 10; c++) step(1'b1, 16'($urandom), 16'($urandom));
        di_en = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_do_en", 32'(do_en), 32'd0);
        check("midrst_do_re", 32'(do_re), 32'd0);
        check("midrst_do_im", 32'(do_im), 32'd0);
        check("midrst_do_last", 32'(do_last), 32'd0);
        check("midrst_tw_addr", 32'(tw_addr), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();

        // Three frames with roughly half the cycles idle.
        n_last = 0;
        acc = 0;
        cyc = 0;
        while (acc < 384 && cyc < 3000) begin
            logic en;
            en = 1'($urandom_range(0, 1));
            step(en, 16'($urandom), 16'($urandom));
            if (en) acc++;
            cyc++;
        end
        check("gap_samples", 32'(acc), 32'd384);
        for (int c = 0; c < 3; c++) step(1'b0, 16'h0, 16'h0);
        check("gap_last_cnt", 32'(n_last), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
